pid_controller: RTL and testbench



---
 rtl/pid_pkg.sv | 27 ++
 rtl/signed_clamp.sv | 31 +++
 rtl/pid_controller.sv | 216 +++++++++++++++++++++
 tb/tb_pid_controller.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared widths, control-mode codes, FSM encoding and limit helper for the PID stage.
package pid_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned PROD_W = 48;
    localparam int unsigned SUM_W  = 50;

    localparam logic [7:0] MODE_POSITION     = 8'd0;
    localparam logic [7:0] MODE_VELOCITY     = 8'd1;
    localparam logic [7:0] MODE_DISPLACEMENT = 8'd2;
    localparam logic [7:0] MODE_DIRECT       = 8'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MUL_P,
        S_MUL_I,
        S_MUL_D,
        S_OUT
    } state_t;

    // Unsigned limit register -> positive magnitude; anything >= 2^23 pins at 2^23-1.
    function automatic logic [DATA_W-2:0] sat_mag(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? '1 : x[DATA_W-2:0];
    endfunction

endpackage

// File: rtl/signed_clamp.sv
// Clamps a signed IN_W-bit value to +/-limit and returns it as a signed OUT_W-bit value.
module signed_clamp #(
    parameter int unsigned IN_W  = 25,
    parameter int unsigned OUT_W = 24
) (
    input  logic signed [IN_W-1:0]  value,
    input  logic        [OUT_W-2:0] limit,
    output logic signed [OUT_W-1:0] result
);

    logic signed [IN_W:0]    v_ext;
    logic signed [IN_W:0]    pos_lim;
    logic signed [IN_W:0]    neg_lim;
    logic signed [OUT_W-1:0] lim_out;

    assign v_ext   = {value[IN_W-1], value};
    assign pos_lim = {{(IN_W-OUT_W+2){1'b0}}, limit};
    assign neg_lim = -pos_lim;
    assign lim_out = {1'b0, limit};

    always_comb begin
        if (v_ext > pos_lim) begin
            result = lim_out;
        end else if (v_ext < neg_lim) begin
            result = -lim_out;
        end else begin
            result = value[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/pid_controller.sv
// PID control law with one time-shared 24x24 multiplier, producing a clamped PWM command.
// Optional output slew limiting is enabled by defining PID_SLEW_LIMIT_EN.
module pid_controller
    import pid_pkg::*;
#(
    parameter int unsigned UPDATE_DIV = 16000,
    parameter int unsigned SLEW_STEP  = 8
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [7:0]               control_mode,
    input  logic signed [DATA_W-1:0] setpoint,
    input  logic signed [DATA_W-1:0] position,
    input  logic signed [DATA_W-1:0] displacement,
    input  logic signed [DATA_W-1:0] Kp,
    input  logic signed [DATA_W-1:0] Ki,
    input  logic signed [DATA_W-1:0] Kd,
    input  logic        [DATA_W-1:0] PWMLimit,
    input  logic        [DATA_W-1:0] IntegralLimit,
    input  logic        [DATA_W-1:0] deadband,
    output logic signed [DATA_W-1:0] pwm,
    output logic                     update_done,
    output logic                     busy
);

    localparam int unsigned PS_W = $clog2(UPDATE_DIV);
    localparam logic [DATA_W-2:0] MAX_MAG = '1;

    state_t state, state_next;

    logic [PS_W-1:0] presc;
    logic            tick;

    logic [7:0]               mode_r, last_mode;
    logic signed [DATA_W-1:0] sp_r, fb_r, kp_r, ki_r, kd_r;
    logic        [DATA_W-2:0] pwm_lim, int_lim;
    logic        [DATA_W-1:0] db_r;
    logic signed [DATA_W-1:0] prev_pos, err_r, derr_r, integral, prev_err;
    logic signed [PROD_W-1:0] prod_p, prod_i, prod_d, product;
    logic signed [DATA_W-1:0] mul_a, mul_b;
    logic signed [DATA_W-1:0] fb_sel;

    logic signed [DATA_W:0]   err_wide, int_wide, derr_wide;
    logic signed [DATA_W-1:0] err_sat, err_db, int_sat, derr_sat;
    logic        [DATA_W-1:0] err_abs;
    logic                     loop_mode, direct_mode;

    logic signed [SUM_W-1:0]  sum, out_in;
    logic signed [DATA_W-1:0] out_sat, pwm_new, pwm_next;

    // ---------------- update-rate prescaler ----------------
    assign tick = (presc == PS_W'(UPDATE_DIV - 1));

    always_ff @(posedge CLK) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PS_W'(1);
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (tick) state_next = S_ERR;
            S_ERR:   state_next = S_MUL_P;
            S_MUL_P: state_next = S_MUL_I;
            S_MUL_I: state_next = S_MUL_D;
            S_MUL_D: state_next = S_OUT;
            S_OUT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != S_IDLE);
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_MUL_P: begin mul_a = kp_r; mul_b = err_r;    end
            S_MUL_I: begin mul_a = ki_r; mul_b = integral; end
            S_MUL_D: begin mul_a = kd_r; mul_b = derr_r;   end
            default: ;
        endcase
    end

    assign product = PROD_W'(mul_a) * PROD_W'(mul_b);

    // ---------------- combinational datapath ----------------
    always_comb begin
        case (control_mode)
            MODE_POSITION:     fb_sel = position;
            MODE_VELOCITY:     fb_sel = position - prev_pos;
            MODE_DISPLACEMENT: fb_sel = displacement;
            default:           fb_sel = '0;
        endcase
    end

    assign loop_mode   = (mode_r <= MODE_DISPLACEMENT);
    assign direct_mode = (mode_r == MODE_DIRECT);

    assign err_wide = {sp_r[DATA_W-1], sp_r} - {fb_r[DATA_W-1], fb_r};
    signed_clamp #(.IN_W(DATA_W+1), .OUT_W(DATA_W)) u_err_sat (
        .value(err_wide), .limit(MAX_MAG), .result(err_sat)
    );

    assign err_abs = err_sat[DATA_W-1] ? DATA_W'(-err_sat) : DATA_W'(err_sat);
    assign err_db  = (err_abs <= db_r) ? '0 : err_sat;

    assign int_wide = {integral[DATA_W-1], integral} + {err_db[DATA_W-1], err_db};
    signed_clamp #(.IN_W(DATA_W+1), .OUT_W(DATA_W)) u_int_sat (
        .value(int_wide), .limit(int_lim), .result(int_sat)
    );

    assign derr_wide = {err_db[DATA_W-1], err_db} - {prev_err[DATA_W-1], prev_err};
    signed_clamp #(.IN_W(DATA_W+1), .OUT_W(DATA_W)) u_derr_sat (
        .value(derr_wide), .limit(MAX_MAG), .result(derr_sat)
    );

    // Direct mode reuses the output clamp on the setpoint instead of the product sum.
    assign sum    = {{(SUM_W-PROD_W){prod_p[PROD_W-1]}}, prod_p}
                  + {{(SUM_W-PROD_W){prod_i[PROD_W-1]}}, prod_i}
                  + {{(SUM_W-PROD_W){prod_d[PROD_W-1]}}, prod_d};
    assign out_in = direct_mode ? {{(SUM_W-DATA_W){sp_r[DATA_W-1]}}, sp_r} : sum;
    signed_clamp #(.IN_W(SUM_W), .OUT_W(DATA_W)) u_out_clamp (
        .value(out_in), .limit(pwm_lim), .result(out_sat)
    );

    assign pwm_new = (loop_mode || direct_mode) ? out_sat : '0;

`ifdef PID_SLEW_LIMIT_EN
    logic signed [DATA_W:0]   slew_diff;
    logic signed [DATA_W-1:0] slew_delta;

    assign slew_diff = {pwm_new[DATA_W-1], pwm_new} - {pwm[DATA_W-1], pwm};
    signed_clamp #(.IN_W(DATA_W+1), .OUT_W(DATA_W)) u_slew_clamp (
        .value(slew_diff), .limit((DATA_W-1)'(SLEW_STEP)), .result(slew_delta)
    );
    assign pwm_next = pwm + slew_delta;
`else
    assign pwm_next = pwm_new;
`endif

    // ---------------- sequential datapath ----------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            pwm         <= '0;
            update_done <= 1'b0;
            integral    <= '0;
            prev_err    <= '0;
            prev_pos    <= '0;
            last_mode   <= '0;
            mode_r      <= '0;
            sp_r        <= '0;
            fb_r        <= '0;
            kp_r        <= '0;
            ki_r        <= '0;
            kd_r        <= '0;
            pwm_lim     <= '0;
            int_lim     <= '0;
            db_r        <= '0;
            err_r       <= '0;
            derr_r      <= '0;
            prod_p      <= '0;
            prod_i      <= '0;
            prod_d      <= '0;
        end else begin
            update_done <= 1'b0;
            case (state)
                S_IDLE: if (tick) begin
                    mode_r   <= control_mode;
                    sp_r     <= setpoint;
                    fb_r     <= fb_sel;
                    kp_r     <= Kp;
                    ki_r     <= Ki;
                    kd_r     <= Kd;
                    pwm_lim  <= sat_mag(PWMLimit);
                    int_lim  <= sat_mag(IntegralLimit);
                    db_r     <= deadband;
                    prev_pos <= position;
                    if (control_mode != last_mode) begin
                        integral  <= '0;
                        prev_err  <= '0;
                        last_mode <= control_mode;
                    end
                end
                S_ERR: begin
                    err_r    <= err_db;
                    derr_r   <= derr_sat;
                    integral <= loop_mode ? int_sat : '0;
                    prev_err <= (loop_mode || direct_mode) ? err_db : '0;
                end
                S_MUL_P: prod_p <= product;
                S_MUL_I: prod_i <= product;
                S_MUL_D: prod_d <= product;
                S_OUT: begin
                    pwm         <= pwm_next;
                    update_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_controller.sv
// Directed self-checking bench for pid_controller (UPDATE_DIV reduced to 16).
module tb_pid_controller;

    logic               CLK = 1'b0;
    logic               reset;
    logic [7:0]         control_mode;
    logic signed [23:0] setpoint, position, displacement, Kp, Ki, Kd;
    logic [23:0]        PWMLimit, IntegralLimit, deadband;
    logic signed [23:0] pwm;
    logic               update_done, busy;

    int errors = 0;
    int checks = 0;

    pid_controller #(.UPDATE_DIV(16), .SLEW_STEP(8)) dut (
        .CLK(CLK), .reset(reset), .control_mode(control_mode),
        .setpoint(setpoint), .position(position), .displacement(displacement),
        .Kp(Kp), .Ki(Ki), .Kd(Kd),
        .PWMLimit(PWMLimit), .IntegralLimit(IntegralLimit), .deadband(deadband),
        .pwm(pwm), .update_done(update_done), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic signed [23:0] obs,
                         input logic signed [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns at the negedge following the update_done pulse (or after a bounded wait).
    task automatic wait_update(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge CLK);
            @(negedge CLK);
            seen = update_done;
        end
        check({tag, "_done"}, 24'(seen), 24'sd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
    endtask

    initial begin
        int cycles;
        logic seen;

        reset = 1'b1;
        control_mode = 8'd0; setpoint = 24'sd100; position = 24'sd40; displacement = '0;
        Kp = 24'sd2; Ki = '0; Kd = '0;
        PWMLimit = 24'd128; IntegralLimit = 24'd1000; deadband = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_pwm", pwm, 24'sd0);
        check("rst_done", 24'(update_done), 24'sd0);
        check("rst_busy", 24'(busy), 24'sd0);

        // Proportional, with latency: tick after edge 15, pwm written on edge 21.
        reset = 1'b0;
        cycles = 0;
        seen = 1'b0;
        while (cycles < 40 && !seen) begin
            @(posedge CLK);
            cycles++;
            @(negedge CLK);
            seen = update_done;
            if (cycles == 16) check("busy_in_update", 24'(busy), 24'sd1);
        end
        check("latency", 24'(cycles), 24'sd21);
        check("p_120", pwm, 24'sd120);
        check("idle_busy", 24'(busy), 24'sd0);
        @(negedge CLK);
        check("done_pulse", 24'(update_done), 24'sd0);

        setpoint = 24'sd200;
        wait_update("p_clamp");
        check("p_clamp", pwm, 24'sd128);

        // Deadband
        deadband = 24'd10; Kp = 24'sd4; setpoint = 24'sd108; position = 24'sd100;
        wait_update("db_in");
        check("db_in", pwm, 24'sd0);
        position = 24'sd90;
        wait_update("db_out");
        check("db_out", pwm, 24'sd72);

        // Integral windup and clear on mode change
        control_mode = 8'd0; Kp = '0; Ki = 24'sd1; Kd = '0; deadband = '0;
        setpoint = 24'sd130; position = 24'sd100; IntegralLimit = 24'd50; PWMLimit = 24'd128;
        do_reset();
        wait_update("i_1");
        check("i_1", pwm, 24'sd30);
        wait_update("i_2");
        check("i_2", pwm, 24'sd50);
        wait_update("i_3");
        check("i_3", pwm, 24'sd50);
        control_mode = 8'd2; displacement = 24'sd100;
        wait_update("i_mode2");
        check("i_mode2", pwm, 24'sd30);

        // Derivative
        control_mode = 8'd0; Kp = '0; Ki = '0; Kd = 24'sd1;
        setpoint = 24'sd100; position = 24'sd100;
        do_reset();
        wait_update("d_0");
        check("d_0", pwm, 24'sd0);
        setpoint = 24'sd120;
        wait_update("d_20");
        check("d_20", pwm, 24'sd20);
        wait_update("d_hold");
        check("d_hold", pwm, 24'sd0);

        // Direct and off modes, limit boundaries
        control_mode = 8'd3; setpoint = -24'sd300; PWMLimit = 24'd128;
        wait_update("direct");
        check("direct", pwm, -24'sd128);
        control_mode = 8'd7;
        wait_update("off");
        check("off", pwm, 24'sd0);
        control_mode = 8'd3; PWMLimit = 24'hFFFFFF;
        wait_update("lim_big");
        check("lim_big", pwm, -24'sd300);
        PWMLimit = 24'd0;
        wait_update("lim_zero");
        check("lim_zero", pwm, 24'sd0);

        // Reset during MUL_I aborts the update and clears the integral
        control_mode = 8'd0; Kp = 24'sd2; Ki = '0; Kd = '0;
        setpoint = 24'sd100; position = 24'sd40;
        PWMLimit = 24'd1000; IntegralLimit = 24'd1000; deadband = '0;
        do_reset();
        wait_update("mr_first");
        check("mr_first", pwm, 24'sd120);
        Ki = 24'sd1;
        repeat (13) @(posedge CLK);
        @(negedge CLK);
        check("mr_busy", 24'(busy), 24'sd1);
        reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("mr_pwm", pwm, 24'sd0);
        check("mr_busy_clr", 24'(busy), 24'sd0);
        check("mr_no_done", 24'(update_done), 24'sd0);
        @(posedge CLK);
        @(negedge CLK);
        check("mr_no_done2", 24'(update_done), 24'sd0);
        reset = 1'b0;
        wait_update("mr_after");
        check("mr_after", pwm, 24'sd180);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
